// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order commit buffer with writeback bypass and mispredict flush
module reorder_buffer #(
  parameter int ROB_SIZE  = 16,
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  output logic                 dec_full,
  output logic [ROB_WIDTH-1:0] dec_rob_id,
  input  logic                 dec_rdy,
  input  logic [1:0]           dec_type,
  input  logic [4:0]           dec_rd,
  input  logic                 dec_ready,
  input  logic [31:0]          dec_value,
  input  logic                 dec_pred_taken,
  input  logic [31:0]          dec_alt_pc,
  input  logic [ROB_WIDTH-1:0] dec_query_j_id,
  input  logic [ROB_WIDTH-1:0] dec_query_k_id,
  output logic                 dec_query_j_ready,
  output logic                 dec_query_k_ready,
  output logic [31:0]          dec_query_j_data,
  output logic [31:0]          dec_query_k_data,
  input  logic                 rs_rdy,
  input  logic [ROB_WIDTH-1:0] rs_rob_id,
  input  logic [31:0]          rs_data,
  input  logic                 rs_set_jump_addr,
  input  logic                 lsb_rdy,
  input  logic [ROB_WIDTH-1:0] lsb_rob_id,
  input  logic [31:0]          lsb_data,
  output logic                 reg_en,
  output logic [4:0]           reg_rd,
  output logic [31:0]          reg_data,
  output logic [ROB_WIDTH-1:0] reg_rob_id,
  output logic                 lsb_commit_en,
  output logic [ROB_WIDTH-1:0] lsb_commit_rob_id,
  output logic                 flush,
  output logic [31:0]          flush_pc
);
  typedef enum logic [1:0] {T_REG, T_STORE, T_BRANCH, T_JALR} rob_type_t;
  logic [ROB_SIZE-1:0]  present, ready, pred, taken;
  rob_type_t            e_type  [ROB_SIZE];
  logic [4:0]           e_rd    [ROB_SIZE];
  logic [31:0]          e_value [ROB_SIZE];
  logic [31:0]          e_alt   [ROB_SIZE];
  logic [ROB_WIDTH-1:0] head, tail;
  logic [ROB_WIDTH:0]   count;
  logic issue, commit, mispredict, rs_wb, lsb_wb, rs_j, rs_k, lsb_j, lsb_k;
  // Handshake decisions for this cycle; full is taken from the registered count only.
  always_comb begin
    issue      = dec_rdy && !dec_full;
    commit     = (count != '0) && ready[head];
    mispredict = commit && (e_type[head] == T_JALR || (e_type[head] == T_BRANCH && taken[head] != pred[head]));
    rs_wb      = rs_rdy && present[rs_rob_id];
    lsb_wb     = lsb_rdy && present[lsb_rob_id] && !(rs_rdy && rs_rob_id == lsb_rob_id);
    rs_j       = rs_rdy && rs_rob_id == dec_query_j_id;
    rs_k       = rs_rdy && rs_rob_id == dec_query_k_id;
    lsb_j      = lsb_rdy && lsb_rob_id == dec_query_j_id;
    lsb_k      = lsb_rdy && lsb_rob_id == dec_query_k_id;
  end
  assign dec_full   = count == (ROB_WIDTH+1)'(ROB_SIZE);
  assign dec_rob_id = tail;
  // Operand lookup with same-cycle writeback bypass; a jump-target writeback leaves the link value in place.
  always_comb begin
    dec_query_j_ready = present[dec_query_j_id] && (ready[dec_query_j_id] || rs_j || lsb_j);
    dec_query_k_ready = present[dec_query_k_id] && (ready[dec_query_k_id] || rs_k || lsb_k);
    dec_query_j_data  = rs_j ? (rs_set_jump_addr ? e_value[dec_query_j_id] : rs_data) :
                        (lsb_j && e_type[dec_query_j_id] != T_STORE) ? lsb_data : e_value[dec_query_j_id];
    dec_query_k_data  = rs_k ? (rs_set_jump_addr ? e_value[dec_query_k_id] : rs_data) :
                        (lsb_k && e_type[dec_query_k_id] != T_STORE) ? lsb_data : e_value[dec_query_k_id];
  end
  // Entry payload: writebacks first so a same-cycle issue to the tail slot overrides them.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      if (rs_wb) begin
        if (rs_set_jump_addr) e_alt[rs_rob_id] <= rs_data;
        else e_value[rs_rob_id] <= rs_data;
        taken[rs_rob_id] <= rs_data[0];
      end
      if (lsb_wb && e_type[lsb_rob_id] != T_STORE) e_value[lsb_rob_id] <= lsb_data;
      if (issue) begin
        e_type[tail]  <= rob_type_t'(dec_type);
        e_rd[tail]    <= dec_rd;
        e_value[tail] <= dec_value;
        e_alt[tail]   <= dec_alt_pc;
        pred[tail]    <= dec_pred_taken;
        taken[tail]   <= dec_pred_taken;
      end
    end
  end
  // Pointers, status bits and registered commit/flush outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      present <= '0;
      ready <= '0;
      reg_en <= 1'b0;
      reg_rd <= '0;
      reg_data <= '0;
      reg_rob_id <= '0;
      lsb_commit_en <= 1'b0;
      lsb_commit_rob_id <= '0;
      flush <= 1'b0;
      flush_pc <= '0;
    end else if (!rdy_in) begin
      reg_en <= 1'b0;
      lsb_commit_en <= 1'b0;
      flush <= 1'b0;
    end else begin
      reg_en <= commit && (e_type[head] == T_REG || e_type[head] == T_JALR);
      lsb_commit_en <= commit && e_type[head] == T_STORE;
      flush <= mispredict;
      if (commit && (e_type[head] == T_REG || e_type[head] == T_JALR)) begin
        reg_rd <= e_rd[head];
        reg_data <= e_value[head];
        reg_rob_id <= head;
      end
      if (commit && e_type[head] == T_STORE) lsb_commit_rob_id <= head;
      if (mispredict) flush_pc <= e_alt[head];
      if (mispredict) begin
        head <= '0;
        tail <= '0;
        count <= '0;
        present <= '0;
        ready <= '0;
      end else begin
        if (rs_wb) ready[rs_rob_id] <= 1'b1;
        if (lsb_wb) ready[lsb_rob_id] <= 1'b1;
        if (commit) begin
          present[head] <= 1'b0;
          ready[head] <= 1'b0;
          head <= head + ROB_WIDTH'(1);
        end
        if (issue) begin
          present[tail] <= 1'b1;
          ready[tail] <= dec_ready;
          tail <= tail + ROB_WIDTH'(1);
        end
        count <= count + (ROB_WIDTH+1)'(issue) - (ROB_WIDTH+1)'(commit);
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed scenarios plus randomized run against a queue-based program-order model
module tb_reorder_buffer;
  logic clk_in = 0, rst_in = 1, rdy_in = 1;
  logic dec_full, dec_rdy, dec_ready, dec_pred_taken;
  logic [3:0] dec_rob_id, dec_query_j_id, dec_query_k_id, rs_rob_id, lsb_rob_id, reg_rob_id, lsb_commit_rob_id;
  logic [1:0] dec_type;
  logic [4:0] dec_rd, reg_rd;
  logic [31:0] dec_value, dec_alt_pc, dec_query_j_data, dec_query_k_data, rs_data, lsb_data, reg_data, flush_pc;
  logic dec_query_j_ready, dec_query_k_ready, rs_rdy, rs_set_jump_addr, lsb_rdy, reg_en, lsb_commit_en, flush;
  int vecs = 0, errs = 0;

  reorder_buffer #(.ROB_SIZE(16), .ROB_WIDTH(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .dec_full(dec_full), .dec_rob_id(dec_rob_id), .dec_rdy(dec_rdy), .dec_type(dec_type),
    .dec_rd(dec_rd), .dec_ready(dec_ready), .dec_value(dec_value), .dec_pred_taken(dec_pred_taken),
    .dec_alt_pc(dec_alt_pc), .dec_query_j_id(dec_query_j_id), .dec_query_k_id(dec_query_k_id),
    .dec_query_j_ready(dec_query_j_ready), .dec_query_k_ready(dec_query_k_ready),
    .dec_query_j_data(dec_query_j_data), .dec_query_k_data(dec_query_k_data),
    .rs_rdy(rs_rdy), .rs_rob_id(rs_rob_id), .rs_data(rs_data), .rs_set_jump_addr(rs_set_jump_addr),
    .lsb_rdy(lsb_rdy), .lsb_rob_id(lsb_rob_id), .lsb_data(lsb_data),
    .reg_en(reg_en), .reg_rd(reg_rd), .reg_data(reg_data), .reg_rob_id(reg_rob_id),
    .lsb_commit_en(lsb_commit_en), .lsb_commit_rob_id(lsb_commit_rob_id),
    .flush(flush), .flush_pc(flush_pc)
  );

  always #5 clk_in = ~clk_in;

  task automatic idle();
    rdy_in = 1; dec_rdy = 0; dec_type = 0; dec_rd = 0; dec_ready = 0; dec_value = 0;
    dec_pred_taken = 0; dec_alt_pc = 0; dec_query_j_id = 0; dec_query_k_id = 0;
    rs_rdy = 0; rs_rob_id = 0; rs_data = 0; rs_set_jump_addr = 0; lsb_rdy = 0; lsb_rob_id = 0; lsb_data = 0;
  endtask

  task automatic tick();
    @(posedge clk_in); #1;
  endtask

  task automatic do_reset();
    idle();
    rst_in = 1; #2; rst_in = 0;
  endtask

  task automatic issue(input logic [1:0] t, input logic [4:0] rd, input logic rdy, input logic [31:0] v,
                       input logic pt, input logic [31:0] alt);
    dec_rdy = 1; dec_type = t; dec_rd = rd; dec_ready = rdy; dec_value = v; dec_pred_taken = pt; dec_alt_pc = alt;
    tick();
    dec_rdy = 0;
  endtask

  task automatic test_reset();
    do_reset();
    vecs++; if (dec_full !== 0 || dec_rob_id !== 0) begin errs++; $display("FAIL reset_ptr: full=%b id=%0d want 0 0", dec_full, dec_rob_id); end
    vecs++; if ({reg_en, lsb_commit_en, flush} !== 3'b000) begin errs++; $display("FAIL reset_pulses: %b want 000", {reg_en, lsb_commit_en, flush}); end
    vecs++; if (reg_data !== 0 || flush_pc !== 0 || reg_rd !== 0) begin errs++; $display("FAIL reset_data: data=%h pc=%h rd=%0d want 0", reg_data, flush_pc, reg_rd); end
  endtask

  task automatic test_issue_commit();
    do_reset();
    issue(0, 5, 1, 32'h11, 0, 0);
    vecs++; if (reg_en !== 0) begin errs++; $display("FAIL ic_latency: reg_en=%b want 0", reg_en); end
    tick();
    vecs++; if ({reg_en, reg_rd, reg_data, reg_rob_id} !== {1'b1, 5'd5, 32'h11, 4'd0}) begin errs++; $display("FAIL ic_commit: en=%b rd=%0d data=%h id=%0d want 1 5 11 0", reg_en, reg_rd, reg_data, reg_rob_id); end
    tick();
    vecs++; if (reg_en !== 0) begin errs++; $display("FAIL ic_pulse: reg_en=%b want 0", reg_en); end
  endtask

  task automatic test_in_order();
    do_reset();
    issue(0, 1, 0, 0, 0, 0);
    issue(0, 2, 0, 0, 0, 0);
    rs_rdy = 1; rs_rob_id = 1; rs_data = 32'hAA; tick();
    vecs++; if (reg_en !== 0) begin errs++; $display("FAIL io_early: reg_en=%b want 0", reg_en); end
    rs_rob_id = 0; rs_data = 32'hBB; tick(); rs_rdy = 0;
    vecs++; if (reg_en !== 0) begin errs++; $display("FAIL io_early2: reg_en=%b want 0", reg_en); end
    tick();
    vecs++; if ({reg_en, reg_data, reg_rob_id} !== {1'b1, 32'hBB, 4'd0}) begin errs++; $display("FAIL io_first: en=%b data=%h id=%0d want 1 bb 0", reg_en, reg_data, reg_rob_id); end
    tick();
    vecs++; if ({reg_en, reg_data, reg_rob_id} !== {1'b1, 32'hAA, 4'd1}) begin errs++; $display("FAIL io_second: en=%b data=%h id=%0d want 1 aa 1", reg_en, reg_data, reg_rob_id); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) issue(0, 5'(i), 0, 0, 0, 0);
    vecs++; if (dec_full !== 1 || dec_rob_id !== 0) begin errs++; $display("FAIL fw_full: full=%b id=%0d want 1 0", dec_full, dec_rob_id); end
    dec_rdy = 1; dec_ready = 1; dec_value = 32'hDEAD; tick();
    vecs++; if (dec_full !== 1 || dec_rob_id !== 0) begin errs++; $display("FAIL fw_ignored: full=%b id=%0d want 1 0", dec_full, dec_rob_id); end
    rs_rdy = 1; rs_rob_id = 0; rs_data = 32'h77; tick(); rs_rdy = 0;
    tick();
    vecs++; if ({dec_full, reg_en, reg_data} !== {1'b0, 1'b1, 32'h77}) begin errs++; $display("FAIL fw_commit: full=%b en=%b data=%h want 0 1 77", dec_full, reg_en, reg_data); end
    tick(); dec_rdy = 0;
    vecs++; if (dec_full !== 1 || dec_rob_id !== 1) begin errs++; $display("FAIL fw_wrap: full=%b id=%0d want 1 1", dec_full, dec_rob_id); end
  endtask

  task automatic test_branch_flush();
    int seen;
    do_reset();
    issue(2, 0, 0, 0, 0, 32'h100);
    issue(0, 3, 1, 32'h33, 0, 0);
    issue(0, 4, 1, 32'h44, 0, 0);
    rs_rdy = 1; rs_rob_id = 0; rs_data = 1; tick(); rs_rdy = 0;
    tick();
    vecs++; if ({flush, flush_pc} !== {1'b1, 32'h100}) begin errs++; $display("FAIL bf_flush: flush=%b pc=%h want 1 100", flush, flush_pc); end
    vecs++; if (dec_rob_id !== 0 || dec_full !== 0) begin errs++; $display("FAIL bf_empty: id=%0d full=%b want 0 0", dec_rob_id, dec_full); end
    seen = 0;
    for (int i = 0; i < 4; i++) begin tick(); seen += int'(reg_en) + int'(flush); end
    vecs++; if (seen !== 0) begin errs++; $display("FAIL bf_younger: %0d pulses after flush want 0", seen); end
  endtask

  task automatic test_query_bypass();
    do_reset();
    for (int i = 0; i < 4; i++) issue(0, 5'(i), 0, 0, 0, 0);
    rs_rdy = 1; rs_rob_id = 3; rs_data = 32'h55; lsb_rdy = 1; lsb_rob_id = 2; lsb_data = 32'h66;
    dec_query_j_id = 3; dec_query_k_id = 2; #1;
    vecs++; if ({dec_query_j_ready, dec_query_j_data} !== {1'b1, 32'h55}) begin errs++; $display("FAIL qb_rs: rdy=%b data=%h want 1 55", dec_query_j_ready, dec_query_j_data); end
    vecs++; if ({dec_query_k_ready, dec_query_k_data} !== {1'b1, 32'h66}) begin errs++; $display("FAIL qb_lsb: rdy=%b data=%h want 1 66", dec_query_k_ready, dec_query_k_data); end
    tick(); rs_rdy = 0; lsb_rdy = 0; dec_query_k_id = 7; #1;
    vecs++; if ({dec_query_j_ready, dec_query_j_data} !== {1'b1, 32'h55}) begin errs++; $display("FAIL qb_stored: rdy=%b data=%h want 1 55", dec_query_j_ready, dec_query_j_data); end
    vecs++; if (dec_query_k_ready !== 0) begin errs++; $display("FAIL qb_absent: rdy=%b want 0", dec_query_k_ready); end
  endtask

  task automatic test_rdy_hold();
    int seen;
    do_reset();
    rdy_in = 0; dec_rdy = 1; dec_ready = 1; dec_value = 32'h22; dec_type = 0;
    tick(); tick(); tick();
    vecs++; if (dec_rob_id !== 0) begin errs++; $display("FAIL rh_noissue: id=%0d want 0", dec_rob_id); end
    rdy_in = 1; tick(); rdy_in = 0; dec_rdy = 0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin tick(); seen += int'(reg_en); end
    vecs++; if (seen !== 0 || dec_rob_id !== 1) begin errs++; $display("FAIL rh_hold: commits=%0d id=%0d want 0 1", seen, dec_rob_id); end
    rdy_in = 1; tick();
    vecs++; if ({reg_en, reg_data} !== {1'b1, 32'h22}) begin errs++; $display("FAIL rh_resume: en=%b data=%h want 1 22", reg_en, reg_data); end
  endtask

  task automatic test_async_reset();
    do_reset();
    issue(0, 9, 1, 32'h99, 0, 0);
    issue(0, 8, 0, 0, 0, 0);
    vecs++; if (reg_en !== 1) begin errs++; $display("FAIL ar_pre: reg_en=%b want 1", reg_en); end
    #2 rst_in = 1; #1;
    vecs++; if ({reg_en, reg_data, dec_rob_id, dec_full} !== {1'b0, 32'h0, 4'd0, 1'b0}) begin errs++; $display("FAIL ar_clear: en=%b data=%h id=%0d full=%b want 0 0 0 0", reg_en, reg_data, dec_rob_id, dec_full); end
    rst_in = 0;
  endtask

  typedef struct {
    int id; int typ; logic [4:0] rd; bit rdy; logic [31:0] val; logic [31:0] alt; bit pred; bit tk;
  } ent_t;

  task automatic test_random();
    ent_t q[$];
    ent_t h;
    int mtail = 0;
    bit full, com, er, jr, kr;
    logic [31:0] jd, kd;
    logic e_reg_en = 0, e_lc_en = 0, e_flush = 0;
    logic [4:0] e_rd = 0;
    logic [31:0] e_data = 0, e_pc = 0;
    logic [3:0] e_rid = 0, e_lid = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rdy_in = $urandom_range(9) != 0;
      dec_rdy = $urandom_range(9) < 6;
      dec_type = ($urandom_range(19) < 10) ? 2'd0 : ($urandom_range(2) == 0) ? 2'd1 : ($urandom_range(5) == 0) ? 2'd3 : 2'd2;
      dec_rd = 5'($urandom); dec_ready = $urandom_range(3) == 0; dec_value = $urandom;
      dec_pred_taken = $urandom_range(1); dec_alt_pc = $urandom;
      rs_rdy = $urandom_range(9) < 4; rs_data = $urandom; rs_set_jump_addr = $urandom_range(9) == 0;
      rs_rob_id = (q.size() > 0 && $urandom_range(3) != 0) ? 4'(q[$urandom_range(q.size() - 1)].id) : 4'($urandom);
      lsb_rdy = $urandom_range(9) < 3; lsb_data = $urandom;
      lsb_rob_id = (q.size() > 0 && $urandom_range(1) != 0) ? 4'(q[$urandom_range(q.size() - 1)].id) : 4'($urandom);
      if (rs_rdy && lsb_rdy && lsb_rob_id == rs_rob_id) lsb_rdy = 0;
      dec_query_j_id = (q.size() > 0) ? 4'(q[$urandom_range(q.size() - 1)].id) : 4'($urandom);
      dec_query_k_id = 4'($urandom);
      #1;
      jr = 0; kr = 0; jd = 0; kd = 0;
      foreach (q[i]) begin
        if (q[i].id == int'(dec_query_j_id)) begin
          jr = q[i].rdy || (rs_rdy && rs_rob_id == dec_query_j_id) || (lsb_rdy && lsb_rob_id == dec_query_j_id);
          jd = (rs_rdy && rs_rob_id == dec_query_j_id && !rs_set_jump_addr) ? rs_data :
               (lsb_rdy && lsb_rob_id == dec_query_j_id && q[i].typ != 1) ? lsb_data : q[i].val;
        end
        if (q[i].id == int'(dec_query_k_id)) begin
          kr = q[i].rdy || (rs_rdy && rs_rob_id == dec_query_k_id) || (lsb_rdy && lsb_rob_id == dec_query_k_id);
          kd = (rs_rdy && rs_rob_id == dec_query_k_id && !rs_set_jump_addr) ? rs_data :
               (lsb_rdy && lsb_rob_id == dec_query_k_id && q[i].typ != 1) ? lsb_data : q[i].val;
        end
      end
      full = q.size() == 16;
      vecs++; if (dec_full !== full || dec_rob_id !== 4'(mtail)) begin errs++; $display("FAIL rnd_alloc c%0d: full=%b id=%0d want %b %0d", c, dec_full, dec_rob_id, full, mtail); end
      vecs++; if (dec_query_j_ready !== jr || (jr && dec_query_j_data !== jd)) begin errs++; $display("FAIL rnd_qj c%0d: rdy=%b data=%h want %b %h", c, dec_query_j_ready, dec_query_j_data, jr, jd); end
      vecs++; if (dec_query_k_ready !== kr || (kr && dec_query_k_data !== kd)) begin errs++; $display("FAIL rnd_qk c%0d: rdy=%b data=%h want %b %h", c, dec_query_k_ready, dec_query_k_data, kr, kd); end
      e_reg_en = 0; e_lc_en = 0; e_flush = 0;
      if (rdy_in) begin
        com = q.size() > 0 && q[0].rdy;
        er = 0;
        if (com) begin
          h = q[0];
          if (h.typ == 0 || h.typ == 3) begin e_reg_en = 1; e_rd = h.rd; e_data = h.val; e_rid = 4'(h.id); end
          if (h.typ == 1) begin e_lc_en = 1; e_lid = 4'(h.id); end
          if (h.typ == 3 || (h.typ == 2 && h.tk != h.pred)) begin e_flush = 1; e_pc = h.alt; er = 1; end
        end
        if (er) begin
          q.delete(); mtail = 0;
        end else begin
          foreach (q[i]) begin
            if (rs_rdy && q[i].id == int'(rs_rob_id)) begin
              q[i].rdy = 1; q[i].tk = rs_data[0];
              if (rs_set_jump_addr) q[i].alt = rs_data; else q[i].val = rs_data;
            end else if (lsb_rdy && q[i].id == int'(lsb_rob_id)) begin
              q[i].rdy = 1;
              if (q[i].typ != 1) q[i].val = lsb_data;
            end
          end
          if (com) void'(q.pop_front());
          if (dec_rdy && !full) begin
            q.push_back('{mtail, int'(dec_type), dec_rd, dec_ready, dec_value, dec_alt_pc, dec_pred_taken, dec_pred_taken});
            mtail = (mtail + 1) % 16;
          end
        end
      end
      tick();
      vecs++; if ({reg_en, lsb_commit_en, flush} !== {e_reg_en, e_lc_en, e_flush}) begin errs++; $display("FAIL rnd_pulse c%0d: reg/lsb/flush=%b want %b", c, {reg_en, lsb_commit_en, flush}, {e_reg_en, e_lc_en, e_flush}); end
      vecs++; if ({reg_rd, reg_data, reg_rob_id} !== {e_rd, e_data, e_rid}) begin errs++; $display("FAIL rnd_reg c%0d: rd=%0d data=%h id=%0d want %0d %h %0d", c, reg_rd, reg_data, reg_rob_id, e_rd, e_data, e_rid); end
      vecs++; if (lsb_commit_rob_id !== e_lid || flush_pc !== e_pc) begin errs++; $display("FAIL rnd_lsb_pc c%0d: lid=%0d pc=%h want %0d %h", c, lsb_commit_rob_id, flush_pc, e_lid, e_pc); end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_issue_commit();
    test_in_order();
    test_full_wrap();
    test_branch_flush();
    test_query_bypass();
    test_rdy_hold();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
